// File: rtl/spiflash_arb.sv
// Two-requester round-robin arbiter in front of a single SPI flash word reader.
// Keeps a one-word last-read buffer and bounds each flash access with a timeout.
module spiflash_arb #(
    parameter int TIMEOUT  = 4095,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    input  logic        inv,
    output logic        f_valid,
    output logic [31:0] f_addr,
    input  logic [31:0] f_rdata,
    input  logic        f_ready,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RELEASE,
        S_RESP
    } state_t;

    // Timeout fires on the ISSUE cycle whose count is TIMEOUT-1, i.e. after TIMEOUT cycles.
    localparam logic [11:0] TO_LIM = (TIMEOUT > 0) ? 12'(TIMEOUT - 1) : 12'd0;

    state_t      state_reg, state_next;
    logic        gnt_reg, gnt_next;
    logic        last_gnt_reg, last_gnt_next;
    logic [21:0] tag_reg, tag_next;
    logic [31:0] data_reg, data_next;
    logic [11:0] cnt_reg, cnt_next;
    logic        buf_valid_reg, buf_valid_next;
    logic [21:0] buf_tag_reg, buf_tag_next;
    logic [31:0] buf_data_reg, buf_data_next;
    logic        f_valid_reg, f_valid_next;
    logic [31:0] f_addr_reg, f_addr_next;
    logic        err_reg, err_next;
    logic [1:0]  ready_reg, ready_next;
    logic [31:0] rdata_reg  [2];
    logic [31:0] rdata_next [2];

    logic [1:0]  req_valid;
    logic        pick;
    logic [21:0] sel_tag;
    logic        hit;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr[31:24], m0_addr[1:0], m1_addr[31:24], m1_addr[1:0]};

    // A requester whose ready is pulsing this cycle still holds valid; mask it to avoid a re-grant.
    assign req_valid = {m1_valid, m0_valid} & ~ready_reg;

    always_comb begin
        pick = 1'b0;
        if (req_valid == 2'b11) begin
            pick = ~last_gnt_reg;
        end else if (req_valid[1]) begin
            pick = 1'b1;
        end
        sel_tag = pick ? m1_addr[23:2] : m0_addr[23:2];
        hit     = CACHE_EN && buf_valid_reg && (buf_tag_reg == sel_tag) && !inv;
    end

    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        last_gnt_next  = last_gnt_reg;
        tag_next       = tag_reg;
        data_next      = data_reg;
        cnt_next       = cnt_reg;
        buf_valid_next = buf_valid_reg;
        buf_tag_next   = buf_tag_reg;
        buf_data_next  = buf_data_reg;
        f_valid_next   = f_valid_reg;
        f_addr_next    = f_addr_reg;
        err_next       = err_reg;
        ready_next     = 2'b00;
        rdata_next     = rdata_reg;

        case (state_reg)
            S_IDLE: begin
                if (req_valid != 2'b00) begin
                    gnt_next    = pick;
                    tag_next    = sel_tag;
                    f_addr_next = {8'h00, sel_tag, 2'b00};
                    if (hit) begin
                        data_next  = buf_data_reg;
                        state_next = S_RESP;
                    end else begin
                        f_valid_next = 1'b1;
                        cnt_next     = 12'd0;
                        state_next   = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (f_ready) begin
                    data_next      = f_rdata;
                    f_valid_next   = 1'b0;
                    buf_tag_next   = tag_reg;
                    buf_data_next  = f_rdata;
                    buf_valid_next = CACHE_EN;
                    state_next     = S_RELEASE;
                end else if (cnt_reg >= TO_LIM) begin
                    err_next     = 1'b1;
                    data_next    = 32'hFFFF_FFFF;
                    f_valid_next = 1'b0;
                    state_next   = S_RELEASE;
                end else if (cnt_reg != 12'hFFF) begin
                    cnt_next = cnt_reg + 12'd1;
                end
            end
            S_RELEASE: begin
                if (!f_ready) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                ready_next[gnt_reg] = 1'b1;
                rdata_next[gnt_reg] = data_reg;
                last_gnt_next       = gnt_reg;
                state_next          = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        // Invalidate has priority over a same-cycle buffer load.
        if (inv) begin
            buf_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            gnt_reg       <= 1'b0;
            last_gnt_reg  <= 1'b1;
            tag_reg       <= '0;
            data_reg      <= '0;
            cnt_reg       <= '0;
            buf_valid_reg <= 1'b0;
            buf_tag_reg   <= '0;
            buf_data_reg  <= '0;
            f_valid_reg   <= 1'b0;
            f_addr_reg    <= '0;
            err_reg       <= 1'b0;
            ready_reg     <= 2'b00;
            rdata_reg[0]  <= '0;
            rdata_reg[1]  <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            last_gnt_reg  <= last_gnt_next;
            tag_reg       <= tag_next;
            data_reg      <= data_next;
            cnt_reg       <= cnt_next;
            buf_valid_reg <= buf_valid_next;
            buf_tag_reg   <= buf_tag_next;
            buf_data_reg  <= buf_data_next;
            f_valid_reg   <= f_valid_next;
            f_addr_reg    <= f_addr_next;
            err_reg       <= err_next;
            ready_reg     <= ready_next;
            rdata_reg[0]  <= rdata_next[0];
            rdata_reg[1]  <= rdata_next[1];
        end
    end

    assign m0_ready = ready_reg[0];
    assign m1_ready = ready_reg[1];
    assign m0_rdata = rdata_reg[0];
    assign m1_rdata = rdata_reg[1];
    assign f_valid  = f_valid_reg;
    assign f_addr   = f_addr_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_spiflash_arb.sv
// Directed bench for spiflash_arb: arbitration, buffer hits/invalidation,
// flash handshake, timeout (second instance with TIMEOUT=16) and mid-access reset.
module tb_spiflash_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid, inv;
    logic [31:0] m0_addr, m1_addr;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        f_valid, f_ready;
    logic [31:0] f_addr, f_rdata;
    logic        err;

    logic        t_m0_valid;
    logic [31:0] t_m0_rdata, t_m1_rdata, t_f_addr;
    logic        t_m0_ready, t_m1_ready, t_f_valid, t_err;

    int n_vec = 0;
    int n_bad = 0;

    int          flash_lat   = 5;
    bit          flash_never = 1'b0;
    int          fcnt        = 0;
    int          txn_count   = 0;
    int          proto_err   = 0;
    logic [31:0] last_faddr  = '0;
    logic        f_valid_q   = 1'b0;

    int   m0_pulses = 0, m1_pulses = 0, wide = 0;
    logic m0_ready_q = 1'b0, m1_ready_q = 1'b0;

    always #5 clk = ~clk;

    spiflash_arb dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .inv(inv),
        .f_valid(f_valid), .f_addr(f_addr), .f_rdata(f_rdata), .f_ready(f_ready),
        .err(err)
    );

    spiflash_arb #(.TIMEOUT(16)) dut_to (
        .clk(clk), .reset(reset),
        .m0_valid(t_m0_valid), .m0_addr(m0_addr), .m0_rdata(t_m0_rdata), .m0_ready(t_m0_ready),
        .m1_valid(1'b0), .m1_addr(32'h0), .m1_rdata(t_m1_rdata), .m1_ready(t_m1_ready),
        .inv(1'b0),
        .f_valid(t_f_valid), .f_addr(t_f_addr), .f_rdata(32'h0), .f_ready(1'b0),
        .err(t_err)
    );

    function automatic logic [31:0] flash_word(input logic [31:0] a);
        case (a)
            32'h0010_0000: return 32'hDEAD_BEEF;
            32'h0010_0004: return 32'h1122_3344;
            32'h0000_0200: return 32'hCAFE_F00D;
            default:       return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    assign f_rdata = flash_word(f_addr);

    // Flash reader: f_ready after flash_lat cycles of f_valid, drops one cycle after f_valid falls.
    always @(posedge clk) begin
        f_valid_q <= f_valid;
        if (reset) begin
            f_ready <= 1'b0;
            fcnt    <= 0;
        end else begin
            if (f_valid && !f_valid_q) begin
                txn_count  <= txn_count + 1;
                last_faddr <= f_addr;
                if (f_ready) proto_err <= proto_err + 1;
            end
            if (!f_valid) begin
                fcnt <= 0;
                if (f_ready) f_ready <= 1'b0;
            end else if (!f_ready) begin
                fcnt <= fcnt + 1;
                if (!flash_never && (fcnt + 1 >= flash_lat)) f_ready <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m0_ready) m0_pulses <= m0_pulses + 1;
        if (m1_ready) m1_pulses <= m1_pulses + 1;
        if ((m0_ready && m0_ready_q) || (m1_ready && m1_ready_q)) wide <= wide + 1;
        m0_ready_q <= m0_ready;
        m1_ready_q <= m1_ready;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // inv_mode: 0 none, 1 inv with the request, 2 inv on the cycle the flash completes.
    task automatic do_read(input int id, input logic [31:0] addr, input int inv_mode,
                           output logic [31:0] data, output int cyc);
        logic rdy;
        bit   inv_done;
        inv_done = 1'b0;
        @(negedge clk);
        if (id == 0) begin m0_addr = addr; m0_valid = 1'b1; end
        else         begin m1_addr = addr; m1_valid = 1'b1; end
        inv = (inv_mode == 1);
        cyc = 0;
        rdy = 1'b0;
        while (!rdy && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            inv = 1'b0;
            rdy = (id == 0) ? m0_ready : m1_ready;
            if (!rdy && inv_mode == 2 && !inv_done && f_valid && f_ready) begin
                inv      = 1'b1;
                inv_done = 1'b1;
            end
        end
        chk($sformatf("m%0d_ready_seen", id), 32'(rdy), 32'd1);
        data = (id == 0) ? m0_rdata : m1_rdata;
        m0_valid = 1'b0;
        m1_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d2;
        int          cyc, t0, p0, p1, got, fv, n;
        int          exp_id [4];
        logic [31:0] exp_d  [2];

        reset = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0; inv = 1'b0;
        t_m0_valid = 1'b0; m0_addr = '0; m1_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_f_valid",  32'(f_valid),  32'd0);
        chk("rst_f_addr",   f_addr,        32'd0);
        chk("rst_m0_ready", 32'(m0_ready), 32'd0);
        chk("rst_m1_ready", 32'(m1_ready), 32'd0);
        chk("rst_m0_rdata", m0_rdata,      32'd0);
        chk("rst_m1_rdata", m1_rdata,      32'd0);
        chk("rst_err",      32'(err),      32'd0);
        reset = 1'b0;

        // Round-robin with both requesters always pending; m0 wins first after reset.
        exp_id = '{0, 1, 0, 1};
        exp_d  = '{32'h5A5A_4A5A, 32'h5A5A_7A5A};
        m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2000;
        p0 = m0_pulses; p1 = m1_pulses;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            m0_valid = 1'b1; m1_valid = 1'b1;
            cyc = 0; got = -1;
            while (got < 0 && cyc < 500) begin
                @(negedge clk);
                cyc++;
                chk("arb_exclusive", 32'(m0_ready & m1_ready), 32'd0);
                if (m0_ready) got = 0;
                else if (m1_ready) got = 1;
            end
            chk($sformatf("arb%0d_grant", k), 32'(got), 32'(exp_id[k]));
            if (got == 0) begin chk($sformatf("arb%0d_data", k), m0_rdata, exp_d[0]); m0_valid = 1'b0; end
            if (got == 1) begin chk($sformatf("arb%0d_data", k), m1_rdata, exp_d[1]); m1_valid = 1'b0; end
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("arb_m0_pulses", 32'(m0_pulses - p0), 32'd2);
        chk("arb_m1_pulses", 32'(m1_pulses - p1), 32'd2);

        // Long flash access.
        flash_lat = 150;
        p0 = m0_pulses; p1 = m1_pulses;
        do_read(0, 32'h0010_0000, 0, d, cyc);
        chk("slow_data", d, 32'hDEAD_BEEF);
        chk("slow_faddr", last_faddr, 32'h0010_0000);
        repeat (3) @(negedge clk);
        chk("slow_m0_pulses", 32'(m0_pulses - p0), 32'd1);
        chk("slow_m1_pulses", 32'(m1_pulses - p1), 32'd0);
        flash_lat = 5;

        // Miss then hit on the same word.
        t0 = txn_count;
        do_read(0, 32'h0010_0004, 0, d, cyc);
        do_read(1, 32'h0010_0004, 0, d2, cyc);
        chk("hit_txns", 32'(txn_count - t0), 32'd1);
        chk("hit_latency", 32'(cyc), 32'd2);
        chk("miss_data", d, 32'h1122_3344);
        chk("hit_data", d2, 32'h1122_3344);

        // inv while idle, then inv together with the lookup: both force a miss.
        @(negedge clk); inv = 1'b1;
        @(negedge clk); inv = 1'b0;
        t0 = txn_count;
        do_read(1, 32'h0010_0004, 0, d, cyc);
        chk("inv_idle_txns", 32'(txn_count - t0), 32'd1);
        chk("inv_idle_data", d, 32'h1122_3344);
        t0 = txn_count;
        do_read(0, 32'h0010_0004, 1, d, cyc);
        chk("inv_lookup_txns", 32'(txn_count - t0), 32'd1);

        // inv at the load cycle wins; upper/lower address bits are ignored.
        do_read(0, 32'h0000_0200, 2, d, cyc);
        chk("inv_load_data", d, 32'hCAFE_F00D);
        t0 = txn_count;
        do_read(0, 32'hAB00_0203, 0, d, cyc);
        chk("inv_load_txns", 32'(txn_count - t0), 32'd1);
        chk("mask_faddr", last_faddr, 32'h0000_0200);
        chk("mask_data", d, 32'hCAFE_F00D);
        chk("m1_rdata_held", m1_rdata, 32'h1122_3344);

        // Reset 20 cycles into ISSUE.
        flash_never = 1'b1;
        @(negedge clk);
        m0_addr = 32'h0030_0000; m0_valid = 1'b1;
        n = 0; cyc = 0;
        while (n < 20 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (f_valid) n++;
        end
        chk("abort_issue_cycles", 32'(n), 32'd20);
        reset = 1'b1; m0_valid = 1'b0;
        @(negedge clk);
        chk("abort_f_valid",  32'(f_valid),  32'd0);
        chk("abort_f_addr",   f_addr,        32'd0);
        chk("abort_m0_ready", 32'(m0_ready), 32'd0);
        chk("abort_m0_rdata", m0_rdata,      32'd0);
        chk("abort_m1_rdata", m1_rdata,      32'd0);
        chk("abort_err",      32'(err),      32'd0);
        @(negedge clk);
        reset = 1'b0; flash_never = 1'b0;
        t0 = txn_count;
        do_read(1, 32'h0010_0000, 0, d, cyc);
        chk("post_abort_data", d, 32'hDEAD_BEEF);
        chk("post_abort_txns", 32'(txn_count - t0), 32'd1);

        // Timeout on the TIMEOUT=16 instance; its flash never answers.
        chk("to_err_pre", 32'(t_err), 32'd0);
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            m0_addr = 32'h0040_0000; t_m0_valid = 1'b1;
            fv = 0; cyc = 0;
            while (!t_m0_ready && cyc < 200) begin
                @(negedge clk);
                cyc++;
                if (t_f_valid) fv++;
            end
            chk($sformatf("to%0d_ready_seen", r), 32'(t_m0_ready), 32'd1);
            chk($sformatf("to%0d_fvalid_cycles", r), 32'(fv), 32'd16);
            chk($sformatf("to%0d_data", r), t_m0_rdata, 32'hFFFF_FFFF);
            chk($sformatf("to%0d_err", r), 32'(t_err), 32'd1);
            chk($sformatf("to%0d_faddr", r), t_f_addr, 32'h0040_0000);
            chk($sformatf("to%0d_m1_ready", r), 32'(t_m1_ready), 32'd0);
            chk($sformatf("to%0d_m1_rdata", r), t_m1_rdata, 32'd0);
            t_m0_valid = 1'b0;
            repeat (10) @(negedge clk);
            chk($sformatf("to%0d_err_sticky", r), 32'(t_err), 32'd1);
        end
        pulse_reset();
        @(negedge clk);
        chk("to_err_cleared", 32'(t_err), 32'd0);

        chk("ready_single_cycle", 32'(wide), 32'd0);
        chk("no_fvalid_while_fready", 32'(proto_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
